// File: rtl/circ_buf_ptr_ctrl.sv
// circ_buf_ptr_ctrl
// Pointer and occupancy controller for a circular buffer that takes
// WRITE_SIZE rows per accepted write and gives READ_SIZE rows per accepted
// read. DEPTH need not be a power of two; every wrap is done with an
// explicit compare-and-subtract.
// Optional feature macro: CIRC_BUF_ERR_STICKY_EN. When it is defined, err is
// a sticky flag that records any request made while its side was blocked.
// When it is undefined, err is tied low.
module circ_buf_ptr_ctrl #(
  parameter int DEPTH      = 8,
  parameter int WRITE_SIZE = 2,
  parameter int READ_SIZE  = 1,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_req,
  output logic             wr_ack,
  output logic [DEPTH-1:0] wr_en,
  input  logic             rd_req,
  output logic             rd_ack,
  output logic [DEPTH-1:0] rd_sel,
  output logic [PW-1:0]    wr_ptr,
  output logic [PW-1:0]    rd_ptr,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             err
);

  // Pointer-domain constants. They are one bit wider than a pointer so that
  // a pointer plus a step, or a row index plus DEPTH, never overflows.
  localparam logic [PW:0] DEPTH_P = (PW + 1)'(DEPTH);
  localparam logic [PW:0] WS_P    = (PW + 1)'(WRITE_SIZE);
  localparam logic [PW:0] RS_P    = (PW + 1)'(READ_SIZE);

  // Count-domain constants. They are one bit wider than count so that the
  // add and subtract below cannot wrap.
  localparam logic [CW:0] WS_C    = (CW + 1)'(WRITE_SIZE);
  localparam logic [CW:0] RS_C    = (CW + 1)'(READ_SIZE);
  localparam logic [CW:0] FULL_TH = (CW + 1)'(DEPTH - WRITE_SIZE);

  logic [PW:0] wr_sum;
  logic [PW:0] rd_sum;
  logic [PW:0] wr_wrap;
  logic [PW:0] rd_wrap;
  logic [CW:0] count_next;

  // Builds a mask of `span` consecutive rows starting at `base`, wrapping
  // modulo DEPTH. Each row's distance from base is compared with the span.
  // This avoids variable bit indexing, which would break for non-power-of-2
  // depths.
  function automatic logic [DEPTH-1:0] row_mask(input logic [PW-1:0] base,
                                                input logic [PW:0]   span);
    logic [DEPTH-1:0] mask;
    logic [PW:0]      row;
    logic [PW:0]      off;
    mask = '0;
    for (int j = 0; j < DEPTH; j++) begin
      row = (PW + 1)'(j);
      if (row >= {1'b0, base}) begin
        off = row - {1'b0, base};
      end else begin
        off = row + DEPTH_P - {1'b0, base};
      end
      mask[j] = (off < span);
    end
    return mask;
  endfunction

  // Status flags and handshakes. Only the registered count is used here, and
  // reset blocks acceptance.
  always_comb begin
    full   = ({1'b0, count} > FULL_TH);
    empty  = ({1'b0, count} < RS_C);
    wr_ack = wr_req & ~full & ~rst;
    rd_ack = rd_req & ~empty & ~rst;
  end

  // Row enables for the buffer array. They are all zero unless that side was
  // accepted.
  always_comb begin
    wr_en  = '0;
    rd_sel = '0;
    if (wr_ack) begin
      wr_en = row_mask(wr_ptr, WS_P);
    end
    if (rd_ack) begin
      rd_sel = row_mask(rd_ptr, RS_P);
    end
  end

  // Next pointer and occupancy values. A single subtract is enough for the
  // wrap because a pointer is below DEPTH and a step is at most DEPTH.
  always_comb begin
    wr_sum  = {1'b0, wr_ptr} + WS_P;
    rd_sum  = {1'b0, rd_ptr} + RS_P;
    wr_wrap = (wr_sum >= DEPTH_P) ? (wr_sum - DEPTH_P) : wr_sum;
    rd_wrap = (rd_sum >= DEPTH_P) ? (rd_sum - DEPTH_P) : rd_sum;
    count_next = {1'b0, count}
               + (wr_ack ? WS_C : '0)
               - (rd_ack ? RS_C : '0);
  end

  // State registers. Reset discards everything held in the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ack) begin
        wr_ptr <= wr_wrap[PW-1:0];
      end
      if (rd_ack) begin
        rd_ptr <= rd_wrap[PW-1:0];
      end
      count <= count_next[CW-1:0];
    end
  end

`ifdef CIRC_BUF_ERR_STICKY_EN
  // Sticky protocol error. It is set by a request made against a full or
  // empty buffer, and only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((wr_req & full) | (rd_req & empty)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
